// File: rtl/md_unit_pkg.sv
// Shared MIPS decode constants and helpers for the multiply/divide unit.
package md_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  typedef enum logic [3:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MFHI,
    MD_MTHI,
    MD_MFLO,
    MD_MTLO
  } md_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_t;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } md_result_t;

  // Classify a raw instruction word into its HI/LO operation, MD_NONE otherwise.
  function automatic md_op_t md_decode_op(input logic [XLEN-1:0] instr);
    md_op_t op;
    op = MD_NONE;
    if (instr[31:26] == OP_SPECIAL) begin
      case (instr[5:0])
        FN_MULT:  op = MD_MULT;
        FN_MULTU: op = MD_MULTU;
        FN_DIV:   op = MD_DIV;
        FN_DIVU:  op = MD_DIVU;
        FN_MFHI:  op = MD_MFHI;
        FN_MTHI:  op = MD_MTHI;
        FN_MFLO:  op = MD_MFLO;
        FN_MTLO:  op = MD_MTLO;
        default:  op = MD_NONE;
      endcase
    end
    return op;
  endfunction

  function automatic logic md_is_class(input md_op_t op);
    return op != MD_NONE;
  endfunction

  function automatic logic md_is_start(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mul(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Pipeline-side signals of the multiply/divide unit.
interface md_unit_if;
  logic [31:0] instr_EXE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] instr_ID;
  logic [31:0] HI_E;
  logic [31:0] LO_E;
  logic        busy;
  logic        md_stall;

  modport master (
    output instr_EXE, RD1_E, RD2_E, instr_ID,
    input  HI_E, LO_E, busy, md_stall
  );

  modport slave (
    input  instr_EXE, RD1_E, RD2_E, instr_ID,
    output HI_E, LO_E, busy, md_stall
  );
endinterface

// File: rtl/md_unit_decode.sv
// Combinational HI/LO instruction classifier; one copy per pipeline stage.
module md_decode
  import md_unit_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output md_op_t          op
);
  assign op = md_decode_op(instr);
endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with the HI/LO hazard stall.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  md_op_t id_op;
  md_op_t ex_op;

  md_decode u_dec_id (.instr(bus.instr_ID),  .op(id_op));
  md_decode u_dec_ex (.instr(bus.instr_EXE), .op(ex_op));

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;
  md_result_t       pend_q, pend_d;
  logic             busy_q, busy_d;
  md_result_t       arith;

  logic [XLEN-1:0]   a, b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dvd, dvs, q_mag, r_mag;
  logic              sgn_div;

  assign a = bus.RD1_E;
  assign b = bus.RD2_E;

  // One multiplier and one magnitude divider shared by signed and unsigned forms.
  always_comb begin
    if (ex_op == MD_MULT)
      prod = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    else
      prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

    sgn_div = (ex_op == MD_DIV);
    dvd     = (sgn_div && a[XLEN-1]) ? XLEN'(0) - a : a;
    dvs     = (sgn_div && b[XLEN-1]) ? XLEN'(0) - b : b;
    q_mag   = (dvs == '0) ? '0 : dvd / dvs;
    r_mag   = (dvs == '0) ? '0 : dvd % dvs;

    if (md_is_mul(ex_op)) begin
      arith.hi = prod[2*XLEN-1:XLEN];
      arith.lo = prod[XLEN-1:0];
    end else if (b == '0) begin
      arith.hi = a;
      arith.lo = '1;
    end else begin
      // 0x80000000 / -1 lands on q=0x80000000, r=0 through the magnitude path.
      arith.lo = (sgn_div && (a[XLEN-1] ^ b[XLEN-1])) ? XLEN'(0) - q_mag : q_mag;
      arith.hi = (sgn_div && a[XLEN-1]) ? XLEN'(0) - r_mag : r_mag;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: start, count down, commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (md_is_start(ex_op)) begin
          state_d = ST_BUSY;
          pend_d  = arith;
          cnt_d   = md_is_mul(ex_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          busy_d  = 1'b1;
        end else if (ex_op == MD_MTHI) begin
          hi_d = bus.RD1_E;
        end else if (ex_op == MD_MTLO) begin
          lo_d = bus.RD1_E;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          hi_d    = pend_q.hi;
          lo_d    = pend_q.lo;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.HI_E     = hi_q;
  assign bus.LO_E     = lo_q;
  assign bus.busy     = busy_q;
  assign bus.md_stall = md_is_class(id_op) && (busy_q || md_is_start(ex_op));

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;

  logic clk;
  logic reset;
  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_ADDU  = 32'h0022_1821;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[9];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic saw_busy;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"mult_neg",  I_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
    vecs[1] = '{"multu_big", I_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"mult_mix",  I_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[3] = '{"div_neg",   I_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[4] = '{"divu",      I_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
    vecs[5] = '{"div_zero",  I_DIV,   32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 10};
    vecs[6] = '{"div_ovf",   I_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[7] = '{"div_negdvd",I_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[8] = '{"divu_zero", I_DIVU,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 10};

    reset         = 1'b0;
    bus.instr_EXE = '0;
    bus.instr_ID  = '0;
    bus.RD1_E     = '0;
    bus.RD2_E     = '0;
    tick();
    tick();
    check("reset_hi", bus.HI_E, 32'h0);
    check("reset_lo", bus.LO_E, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_stall", 32'(bus.md_stall), 32'h0);
    reset = 1'b1;

    // A bubble in EXE must not start anything.
    tick();
    check("bubble_busy", 32'(bus.busy), 32'h0);

    foreach (vecs[i]) begin
      bus.instr_EXE = vecs[i].instr;
      bus.RD1_E     = vecs[i].rd1;
      bus.RD2_E     = vecs[i].rd2;
      tick();
      bus.instr_EXE = '0;
      bus.RD1_E     = '0;
      bus.RD2_E     = '0;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 100) begin
        cnt++;
        tick();
      end
      check({vecs[i].name, "_cycles"}, 32'(cnt), 32'(vecs[i].exp_cycles));
      check({vecs[i].name, "_hi"}, bus.HI_E, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, bus.LO_E, vecs[i].exp_lo);
    end

    // HI/LO consumer in ID behind a non-starting EXE: no stall.
    bus.instr_ID = I_MFLO;
    #1;
    check("stall_idle", 32'(bus.md_stall), 32'h0);

    // Non-md instruction in ID never stalls, even behind a start.
    bus.instr_ID  = I_ADDU;
    bus.instr_EXE = I_MULT;
    #1;
    check("stall_nonmd", 32'(bus.md_stall), 32'h0);

    // mult in EXE with mflo waiting in ID.
    bus.instr_ID = I_MFLO;
    bus.RD1_E    = 32'd3;
    bus.RD2_E    = 32'd5;
    #1;
    check("stall_start", 32'(bus.md_stall), 32'h1);
    tick();
    bus.instr_EXE = '0;
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("stall_busy%0d", c), 32'(bus.md_stall), 32'h1);
      tick();
    end
    check("stall_release", 32'(bus.md_stall), 32'h0);
    check("stall_busy_off", 32'(bus.busy), 32'h0);
    bus.instr_EXE = I_MFLO;
    bus.instr_ID  = '0;
    #1;
    check("mflo_new_lo", bus.LO_E, 32'd15);
    tick();
    bus.instr_EXE = '0;

    // Direct HI/LO writes.
    bus.instr_EXE = I_MTHI;
    bus.RD1_E     = 32'h1234_5678;
    tick();
    check("mthi_hi", bus.HI_E, 32'h1234_5678);
    check("mthi_busy", 32'(bus.busy), 32'h0);
    bus.instr_EXE = I_MTLO;
    bus.RD1_E     = 32'hCAFE_F00D;
    tick();
    check("mtlo_lo", bus.LO_E, 32'hCAFE_F00D);
    check("mtlo_hi_kept", bus.HI_E, 32'h1234_5678);
    bus.instr_EXE = '0;

    // Reset during busy cycle 3 discards the pending result.
    bus.instr_EXE = I_MULT;
    bus.RD1_E     = 32'd7;
    bus.RD2_E     = 32'd6;
    tick();
    bus.instr_EXE = '0;
    tick();
    tick();
    check("midreset_busy_before", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset_busy", 32'(bus.busy), 32'h0);
    check("midreset_hi", bus.HI_E, 32'h0);
    check("midreset_lo", bus.LO_E, 32'h0);
    saw_busy = 1'b0;
    repeat (12) begin
      tick();
      if (bus.busy !== 1'b0) saw_busy = 1'b1;
    end
    check("midreset_no_restart", 32'(saw_busy), 32'h0);
    check("midreset_no_commit_lo", bus.LO_E, 32'h0);
    check("midreset_no_commit_hi", bus.HI_E, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
